snn_lif_conv_core: RTL
======================

Name: snn_lif_conv_core

Overview:
- Parametrised spiking-neural-network core; successor to the fixed-size SNN exercise datapath.
- Receives one kernel and TIMESTEPS image frames over a single streaming handshake.
- Per timestep: valid 2-D convolution (stride 1), then leaky-integrate-and-fire (LIF) update of one membrane potential per output neuron.
- Streams the per-neuron spike counts out in raster order; sits between the testbed pattern driver and downstream readout logic.

Parameters:
- DATA_W, 8, width of img/ker samples (unsigned)
- IMG_SIZE, 4, image edge length (square)
- KER_SIZE, 2, kernel edge length (square), KER_SIZE <= IMG_SIZE
- TIMESTEPS, 2, number of frames per pattern, >= 1
- SHIFT, 0, right shift applied to each convolution result before integration
- THRESH, 7, firing threshold, nonzero, must fit in CONV_W bits
- LEAK_SHIFT, 1, leak divisor exponent (used only with the optional feature)
- OUT_W, 10, spike-count width

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  high for exactly TIMESTEPS*IMG_SIZE^2 consecutive cycles per pattern
- img  input  DATA_W  pixel, raster order, frame after frame
- ker  input  DATA_W  kernel weight, raster order, valid during the first KER_SIZE^2 in_valid cycles only; don't-care afterwards
- out_valid  output  1  output qualifier
- out_data  output  OUT_W  spike count of current neuron, 0 when out_valid low

Behaviour:
- Reset: asynchronous, active-high. Clears out_valid=0, out_data=0, all membrane potentials, spike counters, counters and FSM (IDLE). Reset asserted mid-load or mid-output aborts the pattern. No output is produced for the aborted pattern. The next in_valid rise starts a fresh pattern.
- Derived values:
  - OSZ = IMG_SIZE-KER_SIZE+1
  - NEURONS = OSZ^2
  - CONV_W = 2*DATA_W + clog2(KER_SIZE^2)
  - MEM_W = CONV_W + clog2(TIMESTEPS) + 1
- FSM states:
  - IDLE: waits for in_valid.
  - LOAD: captures kernel and the current frame into buffers; counts pixels.
  - COMPUTE: per frame, for each neuron n (raster order):
    - c = (sum over window of img*ker) >> SHIFT, full CONV_W precision, no truncation before shift.
    - V[n] = V[n] + c.
    - If V[n] >= THRESH: spike, V[n] = V[n] - THRESH (soft reset), cnt[n] += 1.
    - cnt saturates at 2^OUT_W-1. V saturates at 2^MEM_W-1.
    - At most one spike per neuron per timestep.
  - OUTPUT: after the last frame is processed, out_valid is high for exactly NEURONS consecutive cycles, out_data = cnt[0..NEURONS-1]. Then V and cnt are cleared and the FSM returns to IDLE.
- Frame overlap: frame t+1 may arrive while frame t is computed. The core double-buffers the frame, or finishes COMPUTE of frame t within IMG_SIZE^2 cycles. in_valid is never stalled; no sample may be lost.
- Latency: first out_valid no earlier than 1 cycle and no later than NEURONS*KER_SIZE^2 + 16 cycles after in_valid falls.
- out_valid and in_valid are never high in the same cycle.
- in_valid does not rise again until out_valid has fallen.
- Boundaries:
  - KER_SIZE == IMG_SIZE gives NEURONS = 1.
  - TIMESTEPS = 1 gives a single integration step.
  - All-zero kernel gives all counts 0.
  - Maximum inputs must not overflow CONV_W.

Optional Feature:
- Macro SNN_LIF_LEAK_EN.
- Defined: before integration each timestep, V[n] = V[n] - (V[n] >> LEAK_SHIFT), applied from timestep 0. The leak occurs in the same step as the integration; no extra visible latency.
- Undefined: no leak (pure integrate-and-fire); LEAK_SHIFT is ignored.

Test Plan:
- Defaults, no leak: all img=1, all ker=1, 2 frames. Per-step conv=4, V: 4 then 8>=7 fires. Required: 9 outputs all 1, out_valid exactly 9 cycles.
- Same stimulus with SNN_LIF_LEAK_EN, LEAK_SHIFT=1. V: 4, then 4-2+4=6<7. Required: 9 outputs all 0.
- All img=255, ker=255, defaults. conv=260100 each step; one spike per step. Required: all counts 2; no overflow of V.
- Kernel all 0, random img. Required: all counts 0. Also check out_data=0 whenever out_valid=0.
- Assert rst during the 10th in_valid cycle, then a full valid pattern. Required: out_valid stays 0 for the aborted pattern; second pattern outputs match the golden model.
- Back-to-back patterns, 1 idle cycle after out_valid falls. Required: second result is independent of the first (state cleared).

Source files
------------

// File: rtl/snn_lif_conv_core.sv
// Spiking conv core: stride-1 valid convolution feeding leaky integrate-and-fire neurons.
// Optional leak enabled by defining SNN_LIF_LEAK_EN.
module snn_lif_conv_core #(
  parameter int DATA_W     = 8,
  parameter int IMG_SIZE   = 4,
  parameter int KER_SIZE   = 2,
  parameter int TIMESTEPS  = 2,
  parameter int SHIFT      = 0,
  parameter int THRESH     = 7,
  parameter int LEAK_SHIFT = 1,
  parameter int OUT_W      = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] img,
  input  logic [DATA_W-1:0] ker,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_data
);
  localparam int OSZ     = IMG_SIZE - KER_SIZE + 1;
  localparam int NEURONS = OSZ * OSZ;
  localparam int NPIX    = IMG_SIZE * IMG_SIZE;
  localparam int KK      = KER_SIZE * KER_SIZE;
  localparam int CONV_W  = 2 * DATA_W + $clog2(KK);
  localparam int MEM_W   = CONV_W + $clog2(TIMESTEPS) + 1;
  localparam int SUM_W   = MEM_W + 1;
  localparam int PW      = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int NW      = (NEURONS > 1) ? $clog2(NEURONS) : 1;
  localparam int KW      = (KK > 1) ? $clog2(KK) : 1;
  localparam int FW      = (TIMESTEPS > 1) ? $clog2(TIMESTEPS) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, OUTPUT} state_t;

  state_t state, state_n;

  logic              iv_q;
  logic [PW-1:0]     pix;
  logic [FW-1:0]     frame;
  logic              take, start, frame_done, pat_end;

  logic [DATA_W-1:0] img_buf [2][NPIX];
  logic [DATA_W-1:0] ker_buf [KK];

  logic              c_act, c_buf, c_last;
  logic [NW-1:0]     c_n;
  logic [PW-1:0]     orow, ocol;

  logic [MEM_W-1:0]  v_mem [NEURONS];
  logic [OUT_W-1:0]  cnt_mem [NEURONS];

  logic [NW-1:0]     o_idx;
  logic              o_last;

  logic [CONV_W-1:0] acc;
  logic [MEM_W-1:0]  v_cur, v_l, v_sat, v_new;
  logic [SUM_W-1:0]  sum;
  logic              fire;
  logic [OUT_W-1:0]  cnt_new;

  // a pattern only starts on a fresh rise of in_valid
  assign start      = (state == IDLE) && in_valid && !iv_q;
  assign take       = start || ((state == LOAD) && in_valid);
  assign frame_done = take && (pix == PW'(NPIX - 1));
  assign pat_end    = frame_done && (frame == FW'(TIMESTEPS - 1));
  assign c_last     = (c_n == NW'(NEURONS - 1));
  assign o_last     = (o_idx == NW'(NEURONS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = pat_end ? COMPUTE : LOAD;
      LOAD:    if (pat_end) state_n = COMPUTE;
      COMPUTE: if (!c_act) state_n = OUTPUT;
      OUTPUT:  if (o_last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (take) begin
      img_buf[frame[0]][pix] <= img;
      if ((frame == '0) && (int'(pix) < KK))
        ker_buf[KW'(pix)] <= ker;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iv_q  <= 1'b1;
      pix   <= '0;
      frame <= '0;
    end else begin
      iv_q <= in_valid;
      if (take) begin
        if (frame_done) begin
          pix   <= '0;
          frame <= pat_end ? '0 : frame + 1'b1;
        end else begin
          pix <= pix + 1'b1;
        end
      end
    end
  end

  always_comb begin
    acc = '0;
    for (int i = 0; i < KER_SIZE; i++)
      for (int j = 0; j < KER_SIZE; j++)
        acc = acc + CONV_W'(img_buf[c_buf][PW'((int'(orow) + i) * IMG_SIZE + int'(ocol) + j)])
                  * CONV_W'(ker_buf[KW'(i * KER_SIZE + j)]);
  end

  always_comb begin
    v_cur = v_mem[c_n];
`ifdef SNN_LIF_LEAK_EN
    v_l = v_cur - (v_cur >> LEAK_SHIFT);
`else
    v_l = v_cur;
`endif
    sum     = {1'b0, v_l} + SUM_W'(acc >> SHIFT);
    v_sat   = sum[MEM_W] ? '1 : sum[MEM_W-1:0];
    fire    = (v_sat >= MEM_W'(THRESH));
    v_new   = fire ? v_sat - MEM_W'(THRESH) : v_sat;
    cnt_new = (fire && (cnt_mem[c_n] != '1)) ? cnt_mem[c_n] + 1'b1 : cnt_mem[c_n];
  end

`ifndef SNN_LIF_LEAK_EN
  logic leak_unused;
  assign leak_unused = (LEAK_SHIFT != 0);
`endif

  // one neuron per cycle, so a frame finishes before the next one completes loading
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_act <= 1'b0;
      c_buf <= 1'b0;
      c_n   <= '0;
      orow  <= '0;
      ocol  <= '0;
    end else begin
      if (c_act) begin
        c_n <= c_n + 1'b1;
        if (ocol == PW'(OSZ - 1)) begin
          ocol <= '0;
          orow <= orow + 1'b1;
        end else begin
          ocol <= ocol + 1'b1;
        end
        if (c_last) c_act <= 1'b0;
      end
      if (frame_done) begin
        c_act <= 1'b1;
        c_buf <= frame[0];
        c_n   <= '0;
        orow  <= '0;
        ocol  <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NEURONS; k++) begin
        v_mem[k]   <= '0;
        cnt_mem[k] <= '0;
      end
    end else if ((state == OUTPUT) && o_last) begin
      for (int k = 0; k < NEURONS; k++) begin
        v_mem[k]   <= '0;
        cnt_mem[k] <= '0;
      end
    end else if (c_act) begin
      v_mem[c_n]   <= v_new;
      cnt_mem[c_n] <= cnt_new;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_idx     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= (state == OUTPUT);
      out_data  <= (state == OUTPUT) ? cnt_mem[o_idx] : '0;
      if (state == OUTPUT) o_idx <= o_last ? '0 : o_idx + 1'b1;
      else                 o_idx <= '0;
    end
  end

endmodule
